// File: rtl/divisor_punto_fijo.sv
// Sequential signed fixed-point divider, OutDiv = Num / Den in Q(Magnitud).(Precision).
// Restoring division, one quotient bit per clock, fixed latency, saturating result.
module divisor_punto_fijo #(
  parameter int Width     = 24,
  parameter int Magnitud  = 4,
  parameter int Precision = 19,
  parameter int Signo     = 1
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             EnableDiv,
  input  logic [Width-1:0] Num,
  input  logic [Width-1:0] Den,
  output logic [Width-1:0] OutDiv,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Error
);

  // Quotient holds the full word plus Precision extra bits from the pre-shifted dividend
  localparam int QW = Signo + Magnitud + Precision + Precision;
  localparam int CW = $clog2(QW + 1);

  localparam logic [Width-1:0] MAXV = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] MINV = {1'b1, {(Width-1){1'b0}}};
  localparam logic [QW-1:0]    LIM  = {{(QW-Width){1'b0}}, 1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nxt;
  logic [QW-1:0]    dvd;
  logic [QW-1:0]    quo;
  logic [Width:0]   rem;
  logic [Width-1:0] den_abs;
  logic [CW-1:0]    cnt;
  logic             neg, num_neg, num_zero, den_zero;

  logic [Width-1:0] num_abs_in, den_abs_in;
  logic [Width:0]   rem_sh, trial, rem_nxt;
  logic [QW-1:0]    quo_nxt;
  logic [Width-1:0] res;
  logic             res_err, res_dz;
  logic             last;

  // Operand magnitudes; the most negative value maps to 2^(Width-1) exactly
  always_comb begin
    num_abs_in = Num[Width-1] ? (~Num + 1'b1) : Num;
    den_abs_in = Den[Width-1] ? (~Den + 1'b1) : Den;
  end

  // One restoring-division step plus saturation of the final quotient
  always_comb begin
    rem_sh  = {rem[Width-1:0], dvd[QW-1]};
    trial   = rem_sh - {1'b0, den_abs};
    rem_nxt = trial[Width] ? rem_sh : trial;
    quo_nxt = {quo[QW-2:0], ~trial[Width]};
    last    = (cnt == CW'(1));
    res     = '0;
    res_err = 1'b0;
    res_dz  = 1'b0;
    if (den_zero) begin
      res_dz  = 1'b1;
      res_err = 1'b1;
      if (num_zero)     res = '0;
      else if (num_neg) res = MINV;
      else              res = MAXV;
    end else if (!neg) begin
      if (quo_nxt >= LIM) begin
        res     = MAXV;
        res_err = 1'b1;
      end else begin
        res = quo_nxt[Width-1:0];
      end
    end else begin
      if (quo_nxt > LIM) begin
        res     = MINV;
        res_err = 1'b1;
      end else begin
        res = ~quo_nxt[Width-1:0] + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and Busy decode
  always_comb begin
    state_nxt = state;
    Busy      = (state != IDLE);
    case (state)
      IDLE:    if (EnableDiv) state_nxt = CALC;
      CALC:    if (last)      state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration on the last step
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      den_abs  <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      num_neg  <= 1'b0;
      num_zero <= 1'b0;
      den_zero <= 1'b0;
      OutDiv   <= '0;
      Done     <= 1'b0;
      DivZero  <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (EnableDiv) begin
            neg      <= Num[Width-1] ^ Den[Width-1];
            num_neg  <= Num[Width-1];
            num_zero <= (Num == '0);
            den_zero <= (Den == '0);
            den_abs  <= den_abs_in;
            dvd      <= {num_abs_in, {Precision{1'b0}}};
            rem      <= '0;
            quo      <= '0;
            cnt      <= CW'(QW);
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          dvd <= dvd << 1;
          cnt <= cnt - 1'b1;
          // Result is registered as CALC exits so it is valid for the whole FIN cycle
          if (last) begin
            OutDiv  <= res;
            Error   <= res_err;
            DivZero <= res_dz;
            Done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// Directed self-checking bench for divisor_punto_fijo.
module tb_divisor_punto_fijo;

  logic        Clk;
  logic        ResetN;
  logic        EnableDiv;
  logic [23:0] Num;
  logic [23:0] Den;
  logic [23:0] OutDiv;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic        Error;

  int errors = 0;
  int checks = 0;

  divisor_punto_fijo #(.Width(24), .Magnitud(4), .Precision(19), .Signo(1)) dut (
    .Clk(Clk),
    .ResetN(ResetN),
    .EnableDiv(EnableDiv),
    .Num(Num),
    .Den(Den),
    .OutDiv(OutDiv),
    .Busy(Busy),
    .Done(Done),
    .DivZero(DivZero),
    .Error(Error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start from an IDLE negedge, accept on the next posedge, then scramble the inputs
  task automatic do_op(input string tag, input logic [23:0] n, input logic [23:0] d,
                       input logic [23:0] exp_out, input logic exp_err, input logic exp_dz);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    Num = n;
    Den = d;
    EnableDiv = 1'b1;
    @(posedge Clk);
    #1;
    EnableDiv = 1'b0;
    Num = 24'h123456;
    Den = 24'h654321;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 44);
    chk({tag, "_busy"}, busy_cnt, 44);
    chk({tag, "_out"}, OutDiv, exp_out);
    chk({tag, "_err"}, Error, exp_err);
    chk({tag, "_dz"}, DivZero, exp_dz);
    @(negedge Clk);
    chk({tag, "_done_pulse"}, Done, 1'b0);
    chk({tag, "_idle"}, Busy, 1'b0);
    chk({tag, "_hold"}, OutDiv, exp_out);
  endtask

  initial begin
    int d1;
    int d2;
    int seen;
    ResetN = 1'b0;
    EnableDiv = 1'b0;
    Num = '0;
    Den = '0;
    repeat (2) @(negedge Clk);
    chk("rst_out", OutDiv, 24'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_dz", DivZero, 1'b0);
    chk("rst_err", Error, 1'b0);
    ResetN = 1'b1;
    @(negedge Clk);

    do_op("d3_15",   24'h180000, 24'h0C0000, 24'h100000, 1'b0, 1'b0);
    do_op("dm1_4",   24'hF80000, 24'h200000, 24'hFE0000, 1'b0, 1'b0);
    do_op("d1_3",    24'h080000, 24'h180000, 24'h02AAAA, 1'b0, 1'b0);
    do_op("dm1_3",   24'hF80000, 24'h180000, 24'hFD5556, 1'b0, 1'b0);
    do_op("ovf",     24'h400000, 24'h020000, 24'h7FFFFF, 1'b1, 1'b0);
    do_op("udf",     24'hC00000, 24'h020000, 24'h800000, 1'b1, 1'b0);
    do_op("m16_m1",  24'h800000, 24'hF80000, 24'h7FFFFF, 1'b1, 1'b0);
    do_op("m16_1",   24'h800000, 24'h080000, 24'h800000, 1'b0, 1'b0);
    do_op("dz_pos",  24'h080000, 24'h000000, 24'h7FFFFF, 1'b1, 1'b1);
    do_op("dz_neg",  24'hF80000, 24'h000000, 24'h800000, 1'b1, 1'b1);
    do_op("dz_zero", 24'h000000, 24'h000000, 24'h000000, 1'b1, 1'b1);
    do_op("post_dz", 24'h180000, 24'h0C0000, 24'h100000, 1'b0, 1'b0);

    // EnableDiv held high: only IDLE-cycle requests start an operation
    d1 = 0;
    d2 = 0;
    seen = 0;
    Num = 24'h180000;
    Den = 24'h0C0000;
    EnableDiv = 1'b1;
    @(posedge Clk);
    #1;
    Num = 24'hF80000;
    Den = 24'h200000;
    for (int c = 1; c <= 120; c++) begin
      @(negedge Clk);
      if (c == 20) begin
        Num = 24'h080000;
        Den = 24'h180000;
      end
      if (Done) begin
        seen++;
        if (seen == 1) begin
          d1 = c;
          chk("hold_out1", OutDiv, 24'h02AAAA ^ 24'h02AAAA ^ 24'h100000);
        end else begin
          d2 = c;
          chk("hold_out2", OutDiv, 24'h02AAAA);
          EnableDiv = 1'b0;
          break;
        end
      end
    end
    chk("hold_done1", d1, 44);
    chk("hold_done2", d2, 89);
    EnableDiv = 1'b0;
    repeat (2) @(negedge Clk);
    chk("hold_idle", Busy, 1'b0);

    // Reset in the middle of CALC aborts the operation
    Num = 24'h180000;
    Den = 24'h0C0000;
    EnableDiv = 1'b1;
    @(posedge Clk);
    #1;
    EnableDiv = 1'b0;
    repeat (20) @(negedge Clk);
    ResetN = 1'b0;
    @(negedge Clk);
    ResetN = 1'b1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_out", OutDiv, 24'h0);
    seen = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_out_hold", OutDiv, 24'h0);
    do_op("after_rst", 24'h080000, 24'h180000, 24'h02AAAA, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divisor_punto_fijo.md
Name: divisor_punto_fijo

Overview:
- Sequential signed fixed-point divider for the neural-network datapath. It computes OutDiv = Num / Den in the same Q(Magnitud).(Precision) format as the fixed-point multiplier.
- Used for normalisation and the inverse-scaling stages.
- Saturates on overflow, underflow and divide-by-zero, and flags each case on Error.
- Iterative restoring division, one quotient bit per clock, with fixed latency.

Parameters:
- Width, 24: total word width, two's complement.
- Magnitud, 4: integer bits, excluding sign.
- Precision, 19: fractional bits. Width = Signo + Magnitud + Precision.
- Signo, 1: sign bits.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- ResetN  input  1  reset, synchronous and active-low.
- EnableDiv  input  1  start request, sampled only in IDLE.
- Num  input  Width  signed dividend.
- Den  input  Width  signed divisor.
- OutDiv  output  Width  signed quotient, registered; holds until the next Done.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when OutDiv, Error and DivZero are valid.
- DivZero  output  1  registered with OutDiv: Den was 0.
- Error  output  1  registered with OutDiv: overflow, underflow or DivZero.

Behaviour:
- Reset (ResetN=0 at a rising edge):
  - State = IDLE.
  - OutDiv=0, Busy=0, Done=0, DivZero=0, Error=0.
  - Internal registers cleared.
  - Reset during an operation aborts it. No Done is issued and there is no partial output.
- States: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - On EnableDiv=1, latch the operand sign of Num^Den, |Num| and |Den| as Width-bit unsigned. |-2^(Width-1)| = 2^(Width-1) is exact.
  - Latch the den-zero flag.
  - Load the iteration counter with Width+Precision, then go to CALC.
- CALC:
  - Each cycle shifts the next bit of the dividend (|Num| << Precision) into the partial remainder, Width+1 bits.
  - Trial subtract |Den|. If non-negative, keep the difference and set the quotient bit to 1; otherwise set it to 0.
  - Quotient register is Width+Precision bits unsigned. Decrement the counter.
  - Leave CALC after exactly Width+Precision cycles.
  - If Den=0, CALC still runs its full count with the result ignored, so latency stays fixed.
- FIN (one cycle): register the result and pulse Done=1, then return to IDLE. Result rules:
  - Den=0: DivZero=1, Error=1.
    - Num>0 gives 2^(Width-1)-1.
    - Num<0 gives -2^(Width-1).
    - Num=0 gives 0.
  - Positive result with magnitude > 2^(Width-1)-1: OutDiv = 2^(Width-1)-1, Error=1 (overflow).
  - Negative result with magnitude > 2^(Width-1): OutDiv = -2^(Width-1), Error=1 (underflow).
  - Otherwise OutDiv = the sign-applied quotient, truncated toward zero (magnitude truncation), with Error=0 and DivZero=0.
- Latency: accept edge at cycle 0, Done high during cycle Width+Precision+1 (44 with default parameters).
- Throughput: one result every Width+Precision+2 cycles.
- Busy:
  - High from the cycle after accept through the Done cycle inclusive, low in IDLE.
  - EnableDiv while Busy=1, including the Done cycle, is ignored and not queued.
  - Num and Den may change freely after the accept edge.
- Outputs hold their last values between operations. Done is never high for two consecutive cycles.

Test Plan:
- Num=0x180000 (3.0), Den=0x0C0000 (1.5), EnableDiv pulse -> Done exactly 44 cycles after accept, OutDiv=0x100000 (2.0), Error=0, DivZero=0; Busy high 44 cycles.
- Num=0xF80000 (-1.0), Den=0x200000 (4.0) -> OutDiv=0xFE0000 (-0.25). Num=0x080000, Den=0x180000 (1/3) -> 0x02AAAA. Num=0xF80000 (-1), Den=0x180000 -> 0xFD5556 (truncation toward zero).
- Saturation cases:
  - Num=0x400000 (8.0), Den=0x020000 (0.25) -> OutDiv=0x7FFFFF, Error=1.
  - Num=0xC00000 (-8.0), same Den -> 0x800000, Error=1.
  - Num=0x800000, Den=0xF80000 (-16/-1) -> 0x7FFFFF, Error=1.
  - Num=0x800000, Den=0x080000 (-16/1) -> 0x800000, Error=0.
- Den=0 with Num=0x080000 -> 0x7FFFFF; Num=0xF80000 -> 0x800000; Num=0 -> 0x000000. Each with DivZero=1, Error=1, latency still 44.
- EnableDiv held high continuously with changing operands -> only IDLE-cycle requests accepted; results spaced 45 cycles; second operand set captured on the edge after Done.
- ResetN=0 for one edge at CALC cycle 20 -> Busy=0, Done never pulses, OutDiv=0. A new operation accepted immediately after reset completes with correct result.
